// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: (X, Y) -> (K*|v|, atan2(Y, X)).
// One micro-rotation per clock; quadrant pre-rotation folds the left
// half-plane into the right so the core iterations always converge.
// Angle format: 2^32 = 360 deg. Magnitude keeps the CORDIC gain K ~= 1.647.

// Single micro-rotation: drives y toward zero and accumulates the angle used.
module cordic_vector_step #(
  parameter int XW = 18
) (
  input  logic signed [XW-1:0] x,
  input  logic signed [XW-1:0] y,
  input  logic        [31:0]   z,
  input  logic        [4:0]    sh,
  input  logic        [31:0]   atan,
  output logic signed [XW-1:0] xn,
  output logic signed [XW-1:0] yn,
  output logic        [31:0]   zn
);
  logic signed [XW-1:0] xs, ys;

  // Rotate by -/+ atan(2^-sh) depending on the sign of y; both updates
  // use the incoming x/y.
  always_comb begin
    xs = x >>> sh;
    ys = y >>> sh;
    if (!y[XW-1]) begin
      xn = x + ys;
      yn = y - xs;
      zn = z + atan;
    end else begin
      xn = x - ys;
      yn = y + xs;
      zn = z - atan;
    end
  end
endmodule

module cordic_vector #(
  parameter int width = 16,
  parameter int ITER  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [width-1:0] Xin,
  input  logic signed [width-1:0] Yin,
  output logic                    busy,
  output logic                    done,
  output logic        [width:0]   MAGout,
  output logic        [31:0]      ANGLEout
);
  // Two guard bits: one for the K*sqrt(2) growth, one so that negating
  // the most negative input cannot overflow.
  localparam int XW = width + 2;

  typedef enum logic {IDLE, CALC} state_t;

  state_t               state, state_nx;
  logic signed [XW-1:0] x, y, x_nx, y_nx;
  logic signed [XW-1:0] xe, ye, x0, y0;
  logic        [31:0]   z, z_nx, z0;
  logic        [4:0]    i;
  logic                 last;
  logic                 accept;

  // atan(2^-i) scaled so that 2^32 is a full turn, rounded to nearest.
  function automatic logic [31:0] atan_tab(input logic [4:0] k);
    case (k)
      5'd0:  atan_tab = 32'h20000000;
      5'd1:  atan_tab = 32'h12E4051E;
      5'd2:  atan_tab = 32'h09FB385B;
      5'd3:  atan_tab = 32'h051111D4;
      5'd4:  atan_tab = 32'h028B0D43;
      5'd5:  atan_tab = 32'h0145D7E1;
      5'd6:  atan_tab = 32'h00A2F61E;
      5'd7:  atan_tab = 32'h00517C55;
      5'd8:  atan_tab = 32'h0028BE53;
      5'd9:  atan_tab = 32'h00145F2F;
      5'd10: atan_tab = 32'h000A2F98;
      5'd11: atan_tab = 32'h000517CC;
      5'd12: atan_tab = 32'h00028BE6;
      5'd13: atan_tab = 32'h000145F3;
      5'd14: atan_tab = 32'h0000A2FA;
      5'd15: atan_tab = 32'h0000517D;
      5'd16: atan_tab = 32'h000028BE;
      5'd17: atan_tab = 32'h0000145F;
      5'd18: atan_tab = 32'h00000A30;
      5'd19: atan_tab = 32'h00000518;
      5'd20: atan_tab = 32'h0000028C;
      5'd21: atan_tab = 32'h00000146;
      5'd22: atan_tab = 32'h000000A3;
      5'd23: atan_tab = 32'h00000051;
      5'd24: atan_tab = 32'h00000029;
      5'd25: atan_tab = 32'h00000014;
      5'd26: atan_tab = 32'h0000000A;
      5'd27: atan_tab = 32'h00000005;
      5'd28: atan_tab = 32'h00000003;
      5'd29: atan_tab = 32'h00000001;
      5'd30: atan_tab = 32'h00000001;
      default: atan_tab = 32'h00000000;
    endcase
  endfunction

  assign last   = (i == 5'(ITER - 1));
  assign accept = (state == IDLE) && start;
  assign busy   = (state == CALC);

  // Sign-extend operands and fold quadrants II/III into I/IV by +/-90 deg.
  always_comb begin
    xe = {{2{Xin[width-1]}}, Xin};
    ye = {{2{Yin[width-1]}}, Yin};
    x0 = xe;
    y0 = ye;
    z0 = 32'h0;
    if (Xin[width-1]) begin
      if (!Yin[width-1]) begin
        x0 = ye;
        y0 = -xe;
        z0 = 32'h40000000;
      end else begin
        x0 = -ye;
        y0 = xe;
        z0 = 32'hC0000000;
      end
    end
  end

  cordic_vector_step #(.XW(XW)) u_step (
    .x    (x),
    .y    (y),
    .z    (z),
    .sh   (i),
    .atan (atan_tab(i)),
    .xn   (x_nx),
    .yn   (y_nx),
    .zn   (z_nx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state: leave IDLE on start, return after the final iteration.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: load on accept, iterate while busy, publish on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      z        <= '0;
      i        <= '0;
      done     <= 1'b0;
      MAGout   <= '0;
      ANGLEout <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        x <= x0;
        y <= y0;
        z <= z0;
        i <= '0;
      end else if (state == CALC) begin
        x <= x_nx;
        y <= y_nx;
        z <= z_nx;
        i <= i + 5'd1;
        if (last) begin
          // x is non-negative after pre-rotation, so truncation is exact.
          MAGout   <= x_nx[width:0];
          ANGLEout <= z_nx;
          done     <= 1'b1;
          i        <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_cordic_vector.sv
// Directed bench for cordic_vector with a scoreboard queue and a done monitor.
module tb_cordic_vector;
  localparam int W  = 16;
  localparam int IT = 16;
  localparam int ANG_TOL = 131072;

  logic                clk = 1'b0;
  logic                rst, start;
  logic signed [W-1:0] Xin, Yin;
  logic                busy, done;
  logic        [W:0]   MAGout;
  logic        [31:0]  ANGLEout;

  cordic_vector #(.width(W), .ITER(IT)) dut (
    .clk(clk), .rst(rst), .start(start), .Xin(Xin), .Yin(Yin),
    .busy(busy), .done(done), .MAGout(MAGout), .ANGLEout(ANGLEout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          mag;
    logic [31:0] ang;
    bit          ca;
    int          cyc;
    string       nm;
  } exp_t;

  typedef struct {
    int          x;
    int          y;
    int          mag;
    logic [31:0] ang;
    bit          ca;
    string       nm;
  } vec_t;

  exp_t sbq[$];
  int   errors = 0, checks = 0, cyc = 0, ndone = 0, npush = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string nm, input bit ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  // Monitor: every done pulse pops one expectation and compares it.
  exp_t me;
  int   mtol, dang;
  always @(negedge clk) begin
    if (!rst && done) begin
      ndone++;
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1'b0, 1, 0);
      end else begin
        me   = sbq.pop_front();
        mtol = (me.mag == 0) ? 0 : me.mag / 1000 + 4;
        chk({me.nm, "_mag"}, iabs(int'(MAGout) - me.mag) <= mtol, MAGout, me.mag);
        if (me.ca) begin
          dang = int'($signed(ANGLEout - me.ang));
          chk({me.nm, "_ang"}, iabs(dang) <= ANG_TOL, ANGLEout, me.ang);
        end
        chk({me.nm, "_latency"}, cyc == me.cyc, cyc, me.cyc);
        chk({me.nm, "_busy_at_done"}, busy == 1'b0, busy, 0);
      end
    end
  end

  // Drive one start; sync=1 first moves to a falling edge.
  task automatic issue(input vec_t v, input bit sync, input bit push);
    exp_t e;
    if (sync) @(negedge clk);
    start = 1'b1;
    Xin   = 16'(v.x);
    Yin   = 16'(v.y);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.mag = v.mag;
      e.ang = v.ang;
      e.ca  = v.ca;
      e.cyc = cyc + IT;
      e.nm  = v.nm;
      sbq.push_back(e);
      npush++;
    end
  endtask

  // Returns at the falling edge where done is high, or flags a timeout.
  task automatic wait_done(input string nm);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) return;
    end
    chk({nm, "_done_timeout"}, 1'b0, 0, 1);
  endtask

  vec_t vt[8];
  vec_t va, vb, vlb;
  bit   seen;

  initial begin
    vt[0] = '{10000,      0, 16468, 32'h00000000, 1'b1, "x_axis"};
    vt[1] = '{10000,  10000, 23289, 32'h20000000, 1'b1, "deg45"};
    vt[2] = '{    0,  10000, 16468, 32'h40000000, 1'b1, "deg90"};
    vt[3] = '{-10000, 10000, 23289, 32'h60000000, 1'b1, "deg135"};
    vt[4] = '{-10000,     0, 16468, 32'h80000000, 1'b1, "deg180"};
    vt[5] = '{-10000,-10000, 23289, 32'hA0000000, 1'b1, "degm135"};
    vt[6] = '{-32768,-32768, 76314, 32'hA0000000, 1'b1, "extreme"};
    vt[7] = '{    0,      0,     0, 32'h00000000, 1'b0, "zero"};
    va    = '{10000,  10000, 23289, 32'h20000000, 1'b1, "held"};
    vb    = '{-20000,  5000,     0, 32'h00000000, 1'b0, "ignored"};
    vlb   = '{ 8282,  30910, 52698, 32'h35555555, 1'b1, "loopback"};

    rst = 1'b1; start = 1'b0; Xin = '0; Yin = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",  busy == 1'b0,     busy, 0);
    chk("reset_done",  done == 1'b0,     done, 0);
    chk("reset_mag",   MAGout == '0,     MAGout, 0);
    chk("reset_angle", ANGLEout == '0,   ANGLEout, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      issue(vt[k], 1'b1, 1'b1);
      wait_done(vt[k].nm);
    end

    // Start pulsed mid-calculation must not disturb the running operation.
    issue(va, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1; Xin = 16'(vb.x); Yin = 16'(vb.y);
    chk("busy_mid_calc", busy == 1'b1, busy, 1);
    @(negedge clk);
    start = 1'b0;
    wait_done("held");

    // Back-to-back: second start lands in the done cycle of the first.
    issue(vt[0], 1'b1, 1'b1);
    wait_done("b2b_first");
    issue(vt[5], 1'b0, 1'b1);
    wait_done("b2b_second");

    // Reset mid-calculation aborts with no done pulse.
    issue(vt[2], 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy",  busy == 1'b0,   busy, 0);
    chk("abort_done",  done == 1'b0,   done, 0);
    chk("abort_mag",   MAGout == '0,   MAGout, 0);
    chk("abort_angle", ANGLEout == '0, ANGLEout, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", seen == 1'b0, seen, 0);

    issue(vlb, 1'b1, 1'b1);
    wait_done("loopback");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size() == 0, sbq.size(), 0);
    chk("done_count", ndone == npush, ndone, npush);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cordic_vector.md
Name: cordic_vector

Overview:
- Iterative vectoring-mode CORDIC: the inverse of the existing rotation-mode CORDIC. Takes a signed (X, Y) pair and returns the magnitude and the phase angle atan2(Y, X).
- Angle uses the same 32-bit binary format as the rotation core: 2^32 = 360 deg, 0x20000000 = 45 deg.
- Magnitude is left uncompensated: it carries CORDIC gain K ~= 1.647, matching the rotation core's An pre-scale convention.
- Sits beside the rotation core for phase/amplitude recovery of sin/cos pairs.

Parameters:
- width, 16, bit width of signed Xin/Yin.
- ITER, 16, number of micro-rotations; legal range 8..31.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- Xin  input  width  signed X operand; sampled with start.
- Yin  input  width  signed Y operand; sampled with start.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse; MAGout/ANGLEout valid from this cycle.
- MAGout  output  width+1  unsigned magnitude, K*sqrt(X^2+Y^2).
- ANGLEout  output  32  atan2(Y, X) in 2^32 = 360 deg units (two's-complement wrap; 0x80000000 = 180 deg).

Behaviour:
- Reset (rst=1 at a clock edge):
  - busy=0, done=0, MAGout=0, ANGLEout=0, state=IDLE, iteration counter=0.
  - Reset during CALC aborts the operation; no done pulse is issued.
- States are IDLE and CALC.
- IDLE, on an edge with start=1:
  - Register the operands sign-extended to width+2 bits internally (x, y). z is the 32-bit accumulator.
  - Apply quadrant pre-rotation:
    - Xin >= 0: x=X, y=Y, z=0.
    - Xin < 0 and Yin >= 0: x=Y, y=-X, z=0x40000000.
    - Xin < 0 and Yin < 0: x=-Y, y=X, z=0xC0000000.
  - Set counter i=0, busy=1, state=CALC.
- CALC, each edge performs iteration i:
  - y >= 0: x += y>>>i; y -= x>>>i; z += atan_tab[i]. Both updates use the pre-edge x/y values.
  - y < 0: x -= y>>>i; y += x>>>i; z -= atan_tab[i].
  - Shifts are arithmetic.
  - atan_tab[i] = round(atan(2^-i)/(2*pi) * 2^32), a constant table of 32 entries (entry 0 = 0x20000000, entry 1 = 0x12E4051E, ...). Only entries 0..ITER-1 are used.
- Completion, on the edge performing iteration ITER-1:
  - MAGout <= final x, truncated to its low width+1 bits (always non-negative).
  - ANGLEout <= final z.
  - done=1 for exactly the following cycle; busy=0; state=IDLE.
- Latency: start edge to done-high = ITER clock cycles.
- Throughput: a new start may be accepted in the same cycle done is high (back-to-back).
- start while busy=1 is ignored; the operand change has no effect.
- Outputs hold their last values until the next completion. Only reset clears them.
- Width rule: internal x/y are width+2 bits.
  - Worst-case magnitude is 32768*sqrt(2)*1.647 ~= 76324, which fits width+1 unsigned bits.
  - Negating -2^(width-1) must not overflow.
- Zero input (0, 0): MAGout=0; ANGLEout = sum of the iteration sequence with y>=0 always true, a deterministic value. The bench must not check ANGLEout for zero input, only MAGout=0.
- Angle accuracy: within +/-2^17 LSB (~0.011 deg) for ITER=16 and |input| >= 1000.
- Magnitude accuracy: within 0.1% + 4 LSB of 1.6468*sqrt(X^2+Y^2).

Test Plan:
- Xin=10000, Yin=0 -> done exactly 16 cycles after start; ANGLEout ~= 0x00000000; MAGout ~= 16468.
- Xin=10000, Yin=10000 -> ANGLEout ~= 0x20000000 (45 deg); MAGout ~= 23290. Xin=0, Yin=10000 -> ANGLEout ~= 0x40000000; MAGout ~= 16468.
- Xin=-10000, Yin=0 -> ANGLEout ~= 0x80000000 (180 deg). Xin=-10000, Yin=-10000 -> ANGLEout ~= 0xA0000000 (-135 deg). Both must be within the +/-2^17 wrap-aware tolerance.
- Extremes Xin=-32768, Yin=-32768 -> MAGout ~= 76320 with no overflow; ANGLEout ~= 0xA0000000. Xin=0, Yin=0 -> MAGout=0.
- Handshake: pulse start again 5 cycles into CALC with new operands -> ignored; first result is unchanged. Start asserted in the done cycle -> accepted; second done arrives 16 cycles later.
- Assert rst at cycle 8 of CALC -> no done pulse; busy=0, MAGout=0, ANGLEout=0 next cycle. A subsequent start computes correctly.
- Loopback: feed the rotation core outputs for angle 0x35555555 (75 deg, input An=19429) -> ANGLEout within tolerance of 0x35555555; MAGout ~= 1.647*32000 ~= 52700.
